// File: rtl/counter_cmd_seq.sv
// Command sequencer that drives the 4-bit counter's load/count controls from a queued command stream.
// Latency: a command pushed at edge T into an idle sequencer presents its first output cycle after edge T+2; queued commands run back to back.
// Backpressure: cmd_ready drops while the FIFO is full, during abort and while reset is high. Define CNT_SEQ_LEVEL_EN to expose fifo_level.

module counter_cmd_seq_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   push_vld,
    input  logic [W-1:0]           push_dat,
    input  logic                   pop_vld,
    output logic [W-1:0]           pop_dat,
    output logic [$clog2(DEPTH):0] level
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    always_ff @(posedge clk) begin
        if (push_vld) mem[wr_ptr] <= push_dat;
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_vld) wr_ptr <= wr_ptr + 1'b1;
            if (pop_vld)  rd_ptr <= rd_ptr + 1'b1;
            level <= level + {{AW{1'b0}}, push_vld} - {{AW{1'b0}}, pop_vld};
        end
    end

    assign pop_dat = mem[rd_ptr];
endmodule

module counter_cmd_seq #(
    parameter int DATA_W     = 4,
    parameter int LEN_W      = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [DATA_W-1:0] cmd_arg,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic              abort,
    output logic [DATA_W-1:0] data_in,
    output logic              load_en,
    output logic              count_en,
    output logic              up_down,
    output logic              busy,
    output logic              done
`ifdef CNT_SEQ_LEVEL_EN
    ,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
`endif
);
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_UP   = 2'b01;
    localparam logic [1:0] OP_DOWN = 2'b10;

    typedef struct packed {
        logic [1:0]        op;
        logic [DATA_W-1:0] arg;
        logic [LEN_W-1:0]  len;
    } cmd_t;

    typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

    state_t            state;
    cmd_t              push_cmd;
    cmd_t              head;
    logic [1:0]        cur_op;
    logic [DATA_W-1:0] cur_arg;
    logic [LEN_W-1:0]  remaining;
    logic [LEN_W-1:0]  head_len;
    logic [LVL_W-1:0]  level;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    logic              last;
    logic              running;

    assign full      = (level == LVL_W'(FIFO_DEPTH));
    assign empty     = (level == '0);
    assign cmd_ready = !reset && !abort && !full;
    assign push      = cmd_valid && cmd_ready;
    assign push_cmd  = '{op: cmd_op, arg: cmd_arg, len: cmd_len};

    assign running = (state == S_RUN);
    assign last    = running && (remaining == LEN_W'(1));
    assign pop     = !abort && !empty && (!running || last);
    assign busy    = running || !empty;

    // LOAD always lasts one cycle; a zero run length still occupies one cycle.
    assign head_len = (head.op == OP_LOAD || head.len == '0) ? LEN_W'(1) : head.len;

    counter_cmd_seq_fifo #(
        .W     ($bits(cmd_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .flush    (abort),
        .push_vld (push),
        .push_dat (push_cmd),
        .pop_vld  (pop),
        .pop_dat  (head),
        .level    (level)
    );

`ifdef CNT_SEQ_LEVEL_EN
    assign fifo_level = level;
`endif

    // Outputs are a registered image of the command executing this cycle, so they trail the FSM by one edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            cur_op    <= OP_LOAD;
            cur_arg   <= '0;
            remaining <= '0;
            data_in   <= '0;
            load_en   <= 1'b0;
            count_en  <= 1'b0;
            up_down   <= 1'b0;
            done      <= 1'b0;
        end else if (abort) begin
            state     <= S_IDLE;
            remaining <= '0;
            load_en   <= 1'b0;
            count_en  <= 1'b0;
            up_down   <= 1'b0;
            done      <= 1'b0;
        end else begin
            load_en  <= running && (cur_op == OP_LOAD);
            count_en <= running && (cur_op == OP_UP || cur_op == OP_DOWN);
            up_down  <= running && (cur_op == OP_UP);
            done     <= last;
            if (running && cur_op == OP_LOAD) data_in <= cur_arg;

            if (pop) begin
                state     <= S_RUN;
                cur_op    <= head.op;
                cur_arg   <= head.arg;
                remaining <= head_len;
            end else if (last) begin
                state <= S_IDLE;
            end else if (running) begin
                remaining <= remaining - 1'b1;
            end
        end
    end
endmodule
